// File: rtl/scan_pkg.sv
// Shared state encoding and parameter defaults for the scan test sequencer.
package scan_pkg;

    localparam int DEF_CHAIN_LEN = 2;
    localparam int DEF_CNT_W     = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CAPTURE,
        UNLOAD,
        RESP
    } scan_state_e;

endpackage

// File: rtl/scan_shift_reg.sv
// Parallel-load shift register: shifts toward the MSB, serial in at bit 0, serial out from the MSB.
module scan_shift_reg #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_data_i,
    input  logic             shift_i,
    input  logic             ser_i,
    output logic             ser_o,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] data_q;

    // NOTE: this register also drives resp_data, which must read 0 after reset, so it is reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= load_data_i;
        end else if (shift_i) begin
            data_q <= (data_q << 1) | WIDTH'(ser_i);
        end
    end

    assign ser_o  = data_q[WIDTH-1];
    assign data_o = data_q;

endmodule

// File: rtl/scan_test_ctrl.sv
// Scan test sequencer: loads a pattern into the core's chain, applies one capture
// cycle, unloads the response and offers it on a valid/ready interface.
module scan_test_ctrl
    import scan_pkg::*;
#(
    parameter int CHAIN_LEN = DEF_CHAIN_LEN,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pat_valid,
    output logic                 pat_ready,
    input  logic [CHAIN_LEN-1:0] pat_data,
    input  logic                 pat_pi,
    output logic                 scan_en,
    output logic                 scan_in,
    input  logic                 scan_out,
    output logic                 pi_out,
    input  logic                 po_in,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [CHAIN_LEN-1:0] resp_data,
    output logic                 resp_po,
    output logic                 busy,
    output logic [CNT_W-1:0]     pat_count
);

    localparam int              SC_W    = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(CHAIN_LEN - 1);

    scan_state_e      state_q, state_d;
    logic [SC_W-1:0]  shift_cnt_q, shift_cnt_d;
    logic             pi_q, pi_d;
    logic             resp_po_q, resp_po_d;
    logic [CNT_W-1:0] pat_count_q, pat_count_d;
    logic             sr_load, sr_shift, sr_ser_in, sr_ser_out;
    logic             shift_last;

    // One register serves both directions: pattern bits leave from the MSB while
    // response bits enter at bit 0, so the first unloaded bit ends up in resp_data[N-1].
    scan_shift_reg #(
        .WIDTH(CHAIN_LEN)
    ) u_shift (
        .clk        (clk),
        .reset      (reset),
        .load_i     (sr_load),
        .load_data_i(pat_data),
        .shift_i    (sr_shift),
        .ser_i      (sr_ser_in),
        .ser_o      (sr_ser_out),
        .data_o     (resp_data)
    );

    assign shift_last = (shift_cnt_q == SC_LAST);

    // NOTE: non-blocking assignments so every flop samples the pre-edge value of the others.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            shift_cnt_q <= '0;
            pi_q        <= 1'b0;
            resp_po_q   <= 1'b0;
            pat_count_q <= '0;
        end else begin
            state_q     <= state_d;
            shift_cnt_q <= shift_cnt_d;
            pi_q        <= pi_d;
            resp_po_q   <= resp_po_d;
            pat_count_q <= pat_count_d;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
        state_d     = state_q;
        shift_cnt_d = shift_cnt_q;
        pi_d        = pi_q;
        resp_po_d   = resp_po_q;
        pat_count_d = pat_count_q;
        sr_load     = 1'b0;
        sr_shift    = 1'b0;
        sr_ser_in   = 1'b0;
        pat_ready   = 1'b0;
        scan_en     = 1'b0;
        scan_in     = 1'b0;
        pi_out      = 1'b0;
        resp_valid  = 1'b0;
        busy        = 1'b1;

        unique case (state_q)
            IDLE: begin
                pat_ready = 1'b1;
                busy      = 1'b0;
                if (pat_valid) begin
                    sr_load = 1'b1;
                    pi_d    = pat_pi;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                scan_en  = 1'b1;
                scan_in  = sr_ser_out;
                pi_out   = pi_q;
                sr_shift = 1'b1;
                if (shift_last) begin
                    shift_cnt_d = '0;
                    state_d     = CAPTURE;
                end else begin
                    shift_cnt_d = shift_cnt_q + SC_W'(1);
                end
            end
            CAPTURE: begin
                pi_out    = pi_q;
                resp_po_d = po_in;
                state_d   = UNLOAD;
            end
            UNLOAD: begin
                scan_en   = 1'b1;
                pi_out    = pi_q;
                sr_shift  = 1'b1;
                sr_ser_in = scan_out;
                if (shift_last) begin
                    shift_cnt_d = '0;
                    state_d     = RESP;
                end else begin
                    shift_cnt_d = shift_cnt_q + SC_W'(1);
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    pat_count_d = pat_count_q + CNT_W'(1);
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign resp_po   = resp_po_q;
    assign pat_count = pat_count_q;

endmodule

// File: tb/tb_scan_test_ctrl.sv
// Bench for scan_test_ctrl driving a two-flop scan-inserted core model
// (scan_in -> qB -> qC -> scan_out).
module tb_scan_test_ctrl;

    localparam int N       = 2;
    localparam int CW      = 2;
    localparam int CNT_MOD = 1 << CW;
    localparam int LAT     = 2 * N + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          pat_valid, pat_ready, pat_pi;
    logic          scan_en, scan_in, scan_out, pi_out, po_in;
    logic          resp_valid, resp_ready, resp_po, busy;
    logic [N-1:0]  pat_data, resp_data;
    logic [CW-1:0] pat_count;

    logic qb = 1'b0;
    logic qc = 1'b0;

    int total     = 0;
    int bad       = 0;
    int cnt_model = 0;

    typedef struct {
        logic [N-1:0] data;
        logic         pi;
        logic [N-1:0] exp_resp;
        logic         exp_po;
    } vec_t;

    always #5 clk = ~clk;

    scan_test_ctrl #(
        .CHAIN_LEN(N),
        .CNT_W    (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pat_valid (pat_valid),
        .pat_ready (pat_ready),
        .pat_data  (pat_data),
        .pat_pi    (pat_pi),
        .scan_en   (scan_en),
        .scan_in   (scan_in),
        .scan_out  (scan_out),
        .pi_out    (pi_out),
        .po_in     (po_in),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_data (resp_data),
        .resp_po   (resp_po),
        .busy      (busy),
        .pat_count (pat_count)
    );

    // Core: in capture mode qB takes the primary input and qC takes NOR(qB, qC); PO shows qC.
    always @(posedge clk) begin
        if (scan_en) begin
            qb <= scan_in;
            qc <= qb;
        end else begin
            qb <= pi_out;
            qc <= ~(qb | qc);
        end
    end
    assign scan_out = qc;
    assign po_in    = qc;

    // Expected {po, resp[1], resp[0]} for a pattern loaded as flop state d with primary input pi.
    function automatic logic [2:0] golden(input logic [1:0] d, input logic pi);
        return {d[1], ~(d[0] | d[1]), pi};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_resp(input logic pi, input logic noisy, output int lat, output logic [4:0] se);
        lat = 0;
        se  = '0;
        while (!resp_valid && lat < 40) begin
            se = {se[3:0], scan_en};
            check("pi_out while busy", 32'(pi_out), 32'(pi));
            check("busy while busy", 32'(busy), 32'd1);
            check("pat_ready while busy", 32'(pat_ready), 32'd0);
            if (noisy) resp_ready = 1'($urandom);
            @(negedge clk);
            lat++;
        end
        resp_ready = 1'b0;
    endtask

    task automatic handshake();
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        cnt_model  = (cnt_model + 1) % CNT_MOD;
        check("pat_count after handshake", 32'(pat_count), 32'(cnt_model));
        check("resp_valid after handshake", 32'(resp_valid), 32'd0);
        check("pat_ready after handshake", 32'(pat_ready), 32'd1);
    endtask

    task automatic run_pattern(input logic [N-1:0] d, input logic pi, input logic [N-1:0] exp_d,
                               input logic exp_po, input int hold, input logic noisy);
        int         lat;
        logic [4:0] se;
        check("pat_ready idle", 32'(pat_ready), 32'd1);
        pat_valid = 1'b1;
        pat_data  = d;
        pat_pi    = pi;
        @(negedge clk);
        pat_valid = 1'b0;
        pat_data  = N'($urandom);
        pat_pi    = 1'($urandom);
        wait_resp(pi, noisy, lat, se);
        check("latency", 32'(lat), 32'(LAT));
        check("scan_en sequence", 32'(se), 32'b11011);
        check("resp_data", 32'(resp_data), 32'(exp_d));
        check("resp_po", 32'(resp_po), 32'(exp_po));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("held resp_valid", 32'(resp_valid), 32'd1);
            check("held resp_data", 32'(resp_data), 32'(exp_d));
        end
        handshake();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1);
    end

    initial begin
        vec_t          vecs[4];
        logic [2:0]    g;
        logic [2:0]    e;
        logic [N-1:0]  d;
        logic          p;
        int            lat;
        logic [4:0]    se;
        logic [2:0]    exp_q[$];
        int            acc_cyc[5];
        int            n_acc, got, cyc;
        logic          hs;

        vecs[0] = '{2'b01, 1'b1, 2'b01, 1'b0};
        vecs[1] = '{2'b00, 1'b0, 2'b10, 1'b0};
        vecs[2] = '{2'b10, 1'b0, 2'b00, 1'b1};
        vecs[3] = '{2'b11, 1'b1, 2'b01, 1'b1};

        reset      = 1'b1;
        pat_valid  = 1'b0;
        pat_data   = '0;
        pat_pi     = 1'b0;
        resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst scan_en", 32'(scan_en), 32'd0);
        check("rst scan_in", 32'(scan_in), 32'd0);
        check("rst pi_out", 32'(pi_out), 32'd0);
        check("rst resp_valid", 32'(resp_valid), 32'd0);
        check("rst resp_data", 32'(resp_data), 32'd0);
        check("rst resp_po", 32'(resp_po), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst pat_count", 32'(pat_count), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("pat_ready out of reset", 32'(pat_ready), 32'd1);

        // Reset in the second LOAD cycle drops the pattern immediately.
        pat_valid = 1'b1;
        pat_data  = 2'b01;
        pat_pi    = 1'b1;
        @(negedge clk);
        pat_valid = 1'b0;
        @(negedge clk);
        check("load2 scan_en", 32'(scan_en), 32'd1);
        check("load2 scan_in", 32'(scan_in), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("async rst scan_en", 32'(scan_en), 32'd0);
        check("async rst scan_in", 32'(scan_in), 32'd0);
        check("async rst pi_out", 32'(pi_out), 32'd0);
        check("async rst busy", 32'(busy), 32'd0);
        check("async rst resp_valid", 32'(resp_valid), 32'd0);
        check("async rst resp_data", 32'(resp_data), 32'd0);
        check("async rst pat_count", 32'(pat_count), 32'(cnt_model));
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("idle after reset", 32'(pat_ready), 32'd1);

        for (int i = 0; i < 4; i++)
            run_pattern(vecs[i].data, vecs[i].pi, vecs[i].exp_resp, vecs[i].exp_po, 0, 1'b0);

        // Backpressure: a second pattern waits while the response is held.
        pat_valid = 1'b1;
        pat_data  = 2'b10;
        pat_pi    = 1'b0;
        @(negedge clk);
        pat_data  = 2'b11;
        pat_pi    = 1'b1;
        wait_resp(1'b0, 1'b0, lat, se);
        check("bp latency", 32'(lat), 32'(LAT));
        g = golden(2'b10, 1'b0);
        for (int i = 0; i < 10; i++) begin
            check("bp resp_valid", 32'(resp_valid), 32'd1);
            check("bp resp_data", 32'(resp_data), 32'(g[1:0]));
            check("bp resp_po", 32'(resp_po), 32'(g[2]));
            check("bp pat_ready", 32'(pat_ready), 32'd0);
            @(negedge clk);
        end
        handshake();
        @(negedge clk);
        pat_valid = 1'b0;
        check("bp second accepted", 32'(busy), 32'd1);
        wait_resp(1'b1, 1'b0, lat, se);
        check("bp second latency", 32'(lat), 32'(LAT));
        g = golden(2'b11, 1'b1);
        check("bp second resp_data", 32'(resp_data), 32'(g[1:0]));
        check("bp second resp_po", 32'(resp_po), 32'(g[2]));
        handshake();

        for (int i = 0; i < 20; i++) begin
            d = N'($urandom);
            p = 1'($urandom);
            g = golden(d, p);
            run_pattern(d, p, g[1:0], g[2], int'($urandom_range(0, 3)), 1'b1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Back-to-back patterns from a cleared counter: counts 1,2,3,0,1 at full rate.
        reset = 1'b1;
        @(negedge clk);
        reset     = 1'b0;
        cnt_model = 0;
        check("counter cleared", 32'(pat_count), 32'd0);
        for (int i = 0; i < 5; i++) acc_cyc[i] = 0;
        n_acc      = 0;
        got        = 0;
        cyc        = 0;
        resp_ready = 1'b1;
        pat_valid  = 1'b1;
        while (got < 5 && cyc < 300) begin
            hs = 1'b0;
            if (pat_ready) begin
                if (n_acc < 5) begin
                    pat_data = N'($urandom);
                    pat_pi   = 1'($urandom);
                    exp_q.push_back(golden(pat_data, pat_pi));
                    acc_cyc[n_acc] = cyc;
                    n_acc++;
                end else begin
                    pat_valid = 1'b0;
                end
            end
            if (resp_valid) begin
                hs = 1'b1;
                check("b2b queue depth", 32'(exp_q.size()), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("b2b resp_data", 32'(resp_data), 32'(e[1:0]));
                    check("b2b resp_po", 32'(resp_po), 32'(e[2]));
                end
            end
            @(negedge clk);
            cyc++;
            if (hs) begin
                cnt_model = (cnt_model + 1) % CNT_MOD;
                check("b2b pat_count", 32'(pat_count), 32'(cnt_model));
                got++;
            end
        end
        pat_valid  = 1'b0;
        resp_ready = 1'b0;
        check("b2b responses", 32'(got), 32'd5);
        for (int i = 1; i < 5; i++)
            check("b2b spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'(2 * N + 3));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
